hssl_sync_monitor: RTL and testbench
====================================

HSSL_SYNC_MONITOR -- requirements
Module: hssl_sync_monitor

Interface
REQ-001 Parameter BYTES, default 4: bytes per transceiver rx word; width of the per-byte error inputs.
REQ-002 Parameter NUM_CLKC_FOR_SYNC, default 4: consecutive error-free cycles in RESYNC needed to reach SYNC_ACQUIRED.
REQ-003 Parameter NUM_CLKC_FOR_LOSS, default 128: handshake timeout in SYNC_ACQUIRED, in cycles.
REQ-004 Parameter NUM_CLKC_FOR_RX_RESET, default 4: rx datapath reset pulse length, in cycles.
REQ-005 Parameter NUM_CLKC_FOR_IDLE, default 1000: tx electrical-idle duration, in cycles.
REQ-006 Parameter ERR_THRESHOLD, default 4: invalid words tolerated in SYNC_ACQUIRED before loss of sync.
REQ-007 Parameter ERR_WINDOW, default 64: consecutive valid cycles that clear the error level.
REQ-008 Parameter MAX_FAILS, default 8: consecutive failed sync attempts that trigger tx electrical idle.
REQ-009 Parameter CNT_BITS, default 16: width of the statistics counters.
REQ-010 clk  in  1  sole clock; all logic on the rising edge.
REQ-011 reset  in  1  synchronous, active-high reset.
REQ-012 rx_commadet_in  in  1  comma detected by the transceiver.
REQ-013 rx_disperr_in  in  BYTES  per-byte disparity error.
REQ-014 rx_encerr_in  in  BYTES  per-byte 8b/10b encoding error.
REQ-015 handshake_complete_in  in  1  handshake done, from the rx control block.
REQ-016 clr_cnt_in  in  1  clears the statistics counters.
REQ-017 sync_state_out  out  2  encoded as LOSS_OF_SYNC=2'b10, RESYNC=2'b01, SYNC_ACQUIRED=2'b00.
REQ-018 rx_reset_datapath_out  out  1  transceiver rx datapath reset.
REQ-019 tx_elecidle_out  out  1  force the transmitter to electrical idle.
REQ-020 link_up_out  out  1  synchronised and handshake complete.
REQ-021 err_cnt_out  out  CNT_BITS  invalid-word count.
REQ-022 loss_cnt_out  out  CNT_BITS  loss-of-sync event count.

Function
REQ-023 invalid SHALL be the OR of all bits of rx_disperr_in and rx_encerr_in; all outputs SHALL be registered, so each responds one cycle after the sampled input.
REQ-024 LOSS_OF_SYNC: on entry from another state, rx_reset_datapath_out SHALL be 1 for exactly NUM_CLKC_FOR_RX_RESET cycles, then 0. The block SHALL go to RESYNC on the first cycle with rx_commadet_in=1 while rx_reset_datapath_out=0.
REQ-025 RESYNC: invalid SHALL go to LOSS_OF_SYNC. Otherwise, after NUM_CLKC_FOR_SYNC consecutive valid cycles in RESYNC, the block SHALL go to SYNC_ACQUIRED. A comma is not required in RESYNC.
REQ-026 SYNC_ACQUIRED error level: increments on each invalid cycle; returns to 0 after ERR_WINDOW consecutive valid cycles; reaching ERR_THRESHOLD goes to LOSS_OF_SYNC.
REQ-027 SYNC_ACQUIRED handshake timeout: NUM_CLKC_FOR_LOSS consecutive cycles with handshake_complete_in=0 go to LOSS_OF_SYNC. The timeout counter resets while handshake_complete_in=1.
REQ-028 Error-threshold and timeout exit in the same cycle SHALL count as a single loss event.
REQ-029 The error level and all state timers SHALL reset to 0 on every state transition.
REQ-030 link_up_out SHALL be 1 iff sync_state_out=SYNC_ACQUIRED and handshake_complete_in was 1 in the previous cycle.
REQ-031 Failed attempt: an entry to LOSS_OF_SYNC from RESYNC, or from SYNC_ACQUIRED before link_up_out has been 1 in that visit, SHALL increment fail_cnt (saturating at MAX_FAILS). fail_cnt SHALL clear when link_up_out becomes 1.
REQ-032 When fail_cnt reaches MAX_FAILS, tx_elecidle_out SHALL be 1 for NUM_CLKC_FOR_IDLE cycles, then fail_cnt SHALL clear. The state machine SHALL keep running meanwhile.
REQ-033 err_cnt_out SHALL increment on each invalid cycle in RESYNC or SYNC_ACQUIRED; loss_cnt_out SHALL increment on each entry to LOSS_OF_SYNC from another state. Both SHALL saturate at all-ones.
REQ-034 clr_cnt_in=1 SHALL zero both counters next cycle; clear SHALL take precedence over a simultaneous increment.

Reset
REQ-035 Reset SHALL set: sync_state_out=LOSS_OF_SYNC, rx_reset_datapath_out=0, link_up_out=0, counters=0, fail_cnt=0, error level=0.
REQ-036 After reset deasserts, tx_elecidle_out SHALL be 1 for NUM_CLKC_FOR_IDLE cycles, then 0.
REQ-037 Reset-state LOSS_OF_SYNC SHALL NOT generate an rx reset pulse. Reset mid-pulse SHALL abort the pulse.

Verification
REQ-038 Reset release -> tx_elecidle_out=1 for exactly 1000 cycles. Comma at cycle 10 -> RESYNC. 4 clean cycles -> SYNC_ACQUIRED. handshake_complete_in=1 -> link_up_out=1 next cycle.
REQ-039 In SYNC_ACQUIRED, 3 isolated encerr cycles -> state holds. 4th error within window -> LOSS_OF_SYNC, rx_reset_datapath_out=1 for 4 cycles, loss_cnt_out=1, err_cnt_out=4. Errors spaced by at least 64 clean cycles -> never lose sync.
REQ-040 handshake_complete_in held 0 in SYNC_ACQUIRED -> LOSS_OF_SYNC after exactly 128 cycles. Repeat 8 times -> tx_elecidle_out=1 for 1000 cycles.
REQ-041 Disperr on byte BYTES-1 only, during RESYNC -> LOSS_OF_SYNC. Comma asserted during the rx reset pulse -> no RESYNC until the pulse ends.
REQ-042 clr_cnt_in coincident with an invalid word -> err_cnt_out=0. Force err_cnt to 16'hFFFF plus one more error -> stays 16'hFFFF.
REQ-043 Reset asserted in SYNC_ACQUIRED mid rx-reset pulse -> all REQ-035 values next cycle.

Source files
------------

// File: rtl/hssl_sync_monitor_if.sv
// Signal bundle between the transceiver rx path / rx control block and the sync monitor.
// The slave modport is the monitor itself; the master modport is whoever drives it.
interface hssl_sync_monitor_if #(
  parameter int BYTES    = 4,
  parameter int CNT_BITS = 16
);
  logic                rx_commadet_in;
  logic [BYTES-1:0]    rx_disperr_in;
  logic [BYTES-1:0]    rx_encerr_in;
  logic                handshake_complete_in;
  logic                clr_cnt_in;
  logic [1:0]          sync_state_out;
  logic                rx_reset_datapath_out;
  logic                tx_elecidle_out;
  logic                link_up_out;
  logic [CNT_BITS-1:0] err_cnt_out;
  logic [CNT_BITS-1:0] loss_cnt_out;

  modport master (
    output rx_commadet_in, rx_disperr_in, rx_encerr_in, handshake_complete_in, clr_cnt_in,
    input  sync_state_out, rx_reset_datapath_out, tx_elecidle_out, link_up_out,
           err_cnt_out, loss_cnt_out
  );

  modport slave (
    input  rx_commadet_in, rx_disperr_in, rx_encerr_in, handshake_complete_in, clr_cnt_in,
    output sync_state_out, rx_reset_datapath_out, tx_elecidle_out, link_up_out,
           err_cnt_out, loss_cnt_out
  );
endinterface

// File: rtl/hssl_sync_monitor.sv
// 8b/10b link sync monitor: LOSS_OF_SYNC / RESYNC / SYNC_ACQUIRED tracking, rx datapath
// reset pulsing, tx electrical-idle back-off after repeated failed attempts, statistics.
module hssl_sync_monitor #(
  parameter int BYTES                 = 4,
  parameter int NUM_CLKC_FOR_SYNC     = 4,
  parameter int NUM_CLKC_FOR_LOSS     = 128,
  parameter int NUM_CLKC_FOR_RX_RESET = 4,
  parameter int NUM_CLKC_FOR_IDLE     = 1000,
  parameter int ERR_THRESHOLD         = 4,
  parameter int ERR_WINDOW            = 64,
  parameter int MAX_FAILS             = 8,
  parameter int CNT_BITS              = 16
) (
  input logic                clk,
  input logic                reset,
  hssl_sync_monitor_if.slave mon
);

  localparam logic [1:0] ST_SYNC_ACQ = 2'b00;
  localparam logic [1:0] ST_RESYNC   = 2'b01;
  localparam logic [1:0] ST_LOSS     = 2'b10;

  localparam int SW = $clog2(NUM_CLKC_FOR_SYNC + 1);
  localparam int LW = $clog2(NUM_CLKC_FOR_LOSS + 1);
  localparam int RW = $clog2(NUM_CLKC_FOR_RX_RESET + 1);
  localparam int IW = $clog2(NUM_CLKC_FOR_IDLE + 1);
  localparam int EW = $clog2(ERR_THRESHOLD + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic [1:0]          state_r, state_nxt_s;
  logic [SW-1:0]       sync_cnt_r, sync_nxt_s;
  logic [LW-1:0]       to_cnt_r, to_nxt_s;
  logic [EW-1:0]       err_lvl_r, err_lvl_nxt_s;
  logic [WW-1:0]       win_cnt_r, win_nxt_s;
  logic [RW-1:0]       rx_cnt_r;
  logic                rx_reset_r;
  logic [IW-1:0]       idle_cnt_r;
  logic                tx_idle_r;
  logic [FW-1:0]       fail_cnt_r, fail_nxt_s;
  logic                link_up_r, linked_r, link_up_nxt_s;
  logic [CNT_BITS-1:0] err_cnt_r, loss_cnt_r;
  logic                invalid_s, los_entry_s, fail_inc_s, idle_done_s, idle_start_s;

  // Next state and per-state timers; every transition zeroes all timers and the error level.
  always_comb begin
    invalid_s     = (|mon.rx_disperr_in[BYTES-1:0]) | (|mon.rx_encerr_in[BYTES-1:0]);
    state_nxt_s   = state_r;
    sync_nxt_s    = sync_cnt_r;
    to_nxt_s      = to_cnt_r;
    err_lvl_nxt_s = err_lvl_r;
    win_nxt_s     = win_cnt_r;
    case (state_r)
      ST_LOSS: begin
        if (mon.rx_commadet_in && !rx_reset_r) state_nxt_s = ST_RESYNC;
        else                                   state_nxt_s = ST_LOSS;
      end
      ST_RESYNC: begin
        if (invalid_s)                                        state_nxt_s = ST_LOSS;
        else if (sync_cnt_r == SW'(NUM_CLKC_FOR_SYNC - 1))    state_nxt_s = ST_SYNC_ACQ;
        else                                                  sync_nxt_s  = sync_cnt_r + SW'(1);
      end
      ST_SYNC_ACQ: begin
        if (invalid_s) begin
          err_lvl_nxt_s = err_lvl_r + EW'(1);
          win_nxt_s     = '0;
        end else if (err_lvl_r != '0) begin
          if (win_cnt_r == WW'(ERR_WINDOW - 1)) begin
            err_lvl_nxt_s = '0;
            win_nxt_s     = '0;
          end else begin
            win_nxt_s = win_cnt_r + WW'(1);
          end
        end else begin
          win_nxt_s = '0;
        end
        if (mon.handshake_complete_in) to_nxt_s = '0;
        else                           to_nxt_s = to_cnt_r + LW'(1);
        if ((invalid_s && (err_lvl_r == EW'(ERR_THRESHOLD - 1))) ||
            (!mon.handshake_complete_in && (to_cnt_r == LW'(NUM_CLKC_FOR_LOSS - 1))))
          state_nxt_s = ST_LOSS;
        else
          state_nxt_s = ST_SYNC_ACQ;
      end
      default: state_nxt_s = ST_LOSS;
    endcase
    if (state_nxt_s != state_r) begin
      sync_nxt_s    = '0;
      to_nxt_s      = '0;
      err_lvl_nxt_s = '0;
      win_nxt_s     = '0;
    end else begin
      sync_nxt_s    = sync_nxt_s;
    end
  end

  // Loss events, failed-attempt accounting and electrical-idle trigger.
  always_comb begin
    los_entry_s   = (state_nxt_s == ST_LOSS) && (state_r != ST_LOSS);
    fail_inc_s    = los_entry_s && !linked_r;
    link_up_nxt_s = (state_nxt_s == ST_SYNC_ACQ) && mon.handshake_complete_in;
    idle_done_s   = tx_idle_r && (idle_cnt_r == '0);
    if (link_up_nxt_s && !link_up_r)                         fail_nxt_s = '0;
    else if (idle_done_s)                                    fail_nxt_s = '0;
    else if (fail_inc_s && (fail_cnt_r != FW'(MAX_FAILS)))   fail_nxt_s = fail_cnt_r + FW'(1);
    else                                                     fail_nxt_s = fail_cnt_r;
    idle_start_s  = !tx_idle_r && (fail_nxt_s == FW'(MAX_FAILS));
  end

  // State register and timers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_LOSS;
      sync_cnt_r <= '0;
      to_cnt_r   <= '0;
      err_lvl_r  <= '0;
      win_cnt_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      sync_cnt_r <= sync_nxt_s;
      to_cnt_r   <= to_nxt_s;
      err_lvl_r  <= err_lvl_nxt_s;
      win_cnt_r  <= win_nxt_s;
    end
  end

  // Rx datapath reset pulse on loss entry, tx idle timer, link and fail tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_reset_r <= 1'b0;
      rx_cnt_r   <= '0;
      tx_idle_r  <= 1'b1;
      idle_cnt_r <= IW'(NUM_CLKC_FOR_IDLE - 1);
      link_up_r  <= 1'b0;
      linked_r   <= 1'b0;
      fail_cnt_r <= '0;
    end else begin
      if (los_entry_s) begin
        rx_reset_r <= 1'b1;
        rx_cnt_r   <= RW'(NUM_CLKC_FOR_RX_RESET - 1);
      end else if (rx_reset_r) begin
        if (rx_cnt_r == '0) rx_reset_r <= 1'b0;
        else                rx_cnt_r   <= rx_cnt_r - RW'(1);
      end
      if (idle_start_s) begin
        tx_idle_r  <= 1'b1;
        idle_cnt_r <= IW'(NUM_CLKC_FOR_IDLE - 1);
      end else if (tx_idle_r) begin
        if (idle_cnt_r == '0) tx_idle_r  <= 1'b0;
        else                  idle_cnt_r <= idle_cnt_r - IW'(1);
      end
      link_up_r  <= link_up_nxt_s;
      linked_r   <= (state_nxt_s == ST_SYNC_ACQ) && (linked_r || link_up_nxt_s);
      fail_cnt_r <= fail_nxt_s;
    end
  end

  // Saturating statistics; clear wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (reset || mon.clr_cnt_in) begin
      err_cnt_r  <= '0;
      loss_cnt_r <= '0;
    end else begin
      if (invalid_s && (state_r != ST_LOSS) && (err_cnt_r != '1))
        err_cnt_r <= err_cnt_r + CNT_BITS'(1);
      if (los_entry_s && (loss_cnt_r != '1))
        loss_cnt_r <= loss_cnt_r + CNT_BITS'(1);
    end
  end

  assign mon.sync_state_out        = state_r;
  assign mon.rx_reset_datapath_out = rx_reset_r;
  assign mon.tx_elecidle_out       = tx_idle_r;
  assign mon.link_up_out           = link_up_r;
  assign mon.err_cnt_out           = err_cnt_r;
  assign mon.loss_cnt_out          = loss_cnt_r;

endmodule

// File: tb/tb_hssl_sync_monitor.sv
// Directed bench for hssl_sync_monitor: default-parameter instance for the protocol,
// plus a 4-bit-counter instance for counter saturation.
module tb_hssl_sync_monitor;

  localparam logic [1:0] SA = 2'b00;
  localparam logic [1:0] RS = 2'b01;
  localparam logic [1:0] LS = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hssl_sync_monitor_if #(.BYTES(4), .CNT_BITS(16)) mif ();
  hssl_sync_monitor_if #(.BYTES(4), .CNT_BITS(4))  m2 ();

  hssl_sync_monitor dut (.clk(clk), .reset(reset), .mon(mif));
  hssl_sync_monitor #(.CNT_BITS(4), .NUM_CLKC_FOR_IDLE(8)) dut2 (.clk(clk), .reset(reset), .mon(m2));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Comma until RESYNC (bounded), then four clean cycles into SYNC_ACQUIRED.
  task automatic acquire(input logic hs);
    int n = 0;
    mif.handshake_complete_in = hs;
    mif.rx_encerr_in = 4'b0000;
    mif.rx_disperr_in = 4'b0000;
    mif.rx_commadet_in = 1'b1;
    while (mif.sync_state_out !== RS && n < 50) begin
      step();
      n++;
    end
    mif.rx_commadet_in = 1'b0;
    checks++; if (mif.sync_state_out !== RS) begin errors++; $display("FAIL acq_resync: state=%b expected=%b", mif.sync_state_out, RS); end
    repeat (4) step();
    checks++; if (mif.sync_state_out !== SA) begin errors++; $display("FAIL acq_sync: state=%b expected=%b", mif.sync_state_out, SA); end
  endtask

  task automatic test_reset();
    checks++; if (mif.sync_state_out !== LS) begin errors++; $display("FAIL rst_state: got %b expected %b", mif.sync_state_out, LS); end
    checks++; if (mif.rx_reset_datapath_out !== 1'b0) begin errors++; $display("FAIL rst_rxreset: got %b expected 0", mif.rx_reset_datapath_out); end
    checks++; if (mif.link_up_out !== 1'b0) begin errors++; $display("FAIL rst_link: got %b expected 0", mif.link_up_out); end
    checks++; if (mif.err_cnt_out !== 16'h0000) begin errors++; $display("FAIL rst_errcnt: got %0h expected 0", mif.err_cnt_out); end
    checks++; if (mif.loss_cnt_out !== 16'h0000) begin errors++; $display("FAIL rst_losscnt: got %0h expected 0", mif.loss_cnt_out); end
    checks++; if (mif.tx_elecidle_out !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", mif.tx_elecidle_out); end
  endtask

  task automatic test_startup();
    int n = 0;
    reset = 1'b0;
    while (mif.tx_elecidle_out === 1'b1 && n < 2000) begin
      n++;
      mif.rx_commadet_in = (n == 10);
      mif.handshake_complete_in = (n >= 15);
      step();
      if (n == 10) begin checks++; if (mif.sync_state_out !== RS) begin errors++; $display("FAIL start_resync: state=%b expected=%b", mif.sync_state_out, RS); end end
      if (n == 13) begin checks++; if (mif.sync_state_out !== RS) begin errors++; $display("FAIL start_hold3: state=%b expected=%b", mif.sync_state_out, RS); end end
      if (n == 14) begin
        checks++; if (mif.sync_state_out !== SA) begin errors++; $display("FAIL start_sync: state=%b expected=%b", mif.sync_state_out, SA); end
        checks++; if (mif.link_up_out !== 1'b0) begin errors++; $display("FAIL start_nolink: got %b expected 0", mif.link_up_out); end
      end
      if (n == 15) begin checks++; if (mif.link_up_out !== 1'b1) begin errors++; $display("FAIL start_link: got %b expected 1", mif.link_up_out); end end
    end
    checks++; if (n !== 1000) begin errors++; $display("FAIL start_idle_len: got %0d cycles expected 1000", n); end
    checks++; if (mif.sync_state_out !== SA) begin errors++; $display("FAIL start_still_sync: state=%b expected=%b", mif.sync_state_out, SA); end
  endtask

  task automatic test_err_threshold();
    int n = 0;
    repeat (3) begin
      mif.rx_encerr_in = 4'b0001; step();
      mif.rx_encerr_in = 4'b0000; repeat (5) step();
    end
    checks++; if (mif.sync_state_out !== SA) begin errors++; $display("FAIL thr_hold: state=%b expected=%b", mif.sync_state_out, SA); end
    checks++; if (mif.err_cnt_out !== 16'd3) begin errors++; $display("FAIL thr_err3: got %0d expected 3", mif.err_cnt_out); end
    mif.rx_encerr_in = 4'b0100; step();
    mif.rx_encerr_in = 4'b0000;
    checks++; if (mif.sync_state_out !== LS) begin errors++; $display("FAIL thr_loss: state=%b expected=%b", mif.sync_state_out, LS); end
    checks++; if (mif.loss_cnt_out !== 16'd1) begin errors++; $display("FAIL thr_losscnt: got %0d expected 1", mif.loss_cnt_out); end
    checks++; if (mif.err_cnt_out !== 16'd4) begin errors++; $display("FAIL thr_err4: got %0d expected 4", mif.err_cnt_out); end
    checks++; if (mif.link_up_out !== 1'b0) begin errors++; $display("FAIL thr_linkdown: got %b expected 0", mif.link_up_out); end
    while (mif.rx_reset_datapath_out === 1'b1 && n < 20) begin n++; step(); end
    checks++; if (n !== 4) begin errors++; $display("FAIL thr_pulse_len: got %0d cycles expected 4", n); end
  endtask

  task automatic test_err_window();
    acquire(1'b1);
    for (int i = 0; i < 6; i++) begin
      mif.rx_encerr_in = 4'b0010; step();
      mif.rx_encerr_in = 4'b0000; repeat (64) step();
      checks++; if (mif.sync_state_out !== SA) begin errors++; $display("FAIL win64_hold%0d: state=%b expected=%b", i, mif.sync_state_out, SA); end
    end
    for (int i = 0; i < 4; i++) begin
      mif.rx_encerr_in = 4'b0010; step();
      mif.rx_encerr_in = 4'b0000;
      if (i < 3) repeat (63) step();
    end
    checks++; if (mif.sync_state_out !== LS) begin errors++; $display("FAIL win63_loss: state=%b expected=%b", mif.sync_state_out, LS); end
    checks++; if (mif.err_cnt_out !== 16'd14) begin errors++; $display("FAIL win_errcnt: got %0d expected 14", mif.err_cnt_out); end
    checks++; if (mif.loss_cnt_out !== 16'd2) begin errors++; $display("FAIL win_losscnt: got %0d expected 2", mif.loss_cnt_out); end
  endtask

  task automatic test_comma_during_pulse();
    int n = 0;
    int early = 0;
    mif.rx_commadet_in = 1'b1;
    while (mif.rx_reset_datapath_out === 1'b1 && n < 20) begin
      if (mif.sync_state_out !== LS) early++;
      n++;
      step();
    end
    checks++; if (early !== 0 || mif.sync_state_out !== LS) begin errors++; $display("FAIL pulse_comma_hold: state=%b early=%0d expected state %b", mif.sync_state_out, early, LS); end
    step();
    checks++; if (mif.sync_state_out !== RS) begin errors++; $display("FAIL pulse_comma_resync: state=%b expected=%b", mif.sync_state_out, RS); end
    mif.rx_commadet_in = 1'b0;
    mif.handshake_complete_in = 1'b1;
    repeat (4) step();
    checks++; if (mif.link_up_out !== 1'b1) begin errors++; $display("FAIL pulse_relink: got %b expected 1", mif.link_up_out); end
  endtask

  task automatic test_timeout();
    int n = 0;
    mif.handshake_complete_in = 1'b0;
    while (mif.sync_state_out === SA && n < 300) begin n++; step(); end
    checks++; if (n !== 128) begin errors++; $display("FAIL to_linked_len: got %0d cycles expected 128", n); end
    checks++; if (mif.tx_elecidle_out !== 1'b0) begin errors++; $display("FAIL to_linked_noidle: got %b expected 0", mif.tx_elecidle_out); end
    checks++; if (mif.loss_cnt_out !== 16'd3) begin errors++; $display("FAIL to_losscnt: got %0d expected 3", mif.loss_cnt_out); end
    for (int i = 0; i < 8; i++) begin
      acquire(1'b0);
      n = 0;
      while (mif.sync_state_out === SA && n < 300) begin n++; step(); end
      checks++; if (n !== 128) begin errors++; $display("FAIL to_len%0d: got %0d cycles expected 128", i, n); end
      checks++; if (mif.tx_elecidle_out !== (i == 7)) begin errors++; $display("FAIL to_idle%0d: got %b expected %b", i, mif.tx_elecidle_out, (i == 7)); end
    end
    n = 0;
    while (mif.tx_elecidle_out === 1'b1 && n < 2000) begin n++; step(); end
    checks++; if (n !== 1000) begin errors++; $display("FAIL to_idle_len: got %0d cycles expected 1000", n); end
    acquire(1'b0);
    n = 0;
    while (mif.sync_state_out === SA && n < 300) begin n++; step(); end
    checks++; if (mif.tx_elecidle_out !== 1'b0) begin errors++; $display("FAIL to_failclr: got %b expected 0", mif.tx_elecidle_out); end
    checks++; if (mif.loss_cnt_out !== 16'd12) begin errors++; $display("FAIL to_losscnt12: got %0d expected 12", mif.loss_cnt_out); end
  endtask

  task automatic test_disperr_msb();
    int n = 0;
    mif.rx_commadet_in = 1'b1;
    while (mif.sync_state_out !== RS && n < 50) begin step(); n++; end
    mif.rx_commadet_in = 1'b0;
    mif.rx_disperr_in = 4'b1000; step();
    mif.rx_disperr_in = 4'b0000;
    checks++; if (mif.sync_state_out !== LS) begin errors++; $display("FAIL msb_loss: state=%b expected=%b", mif.sync_state_out, LS); end
    checks++; if (mif.err_cnt_out !== 16'd15) begin errors++; $display("FAIL msb_errcnt: got %0d expected 15", mif.err_cnt_out); end
    checks++; if (mif.loss_cnt_out !== 16'd13) begin errors++; $display("FAIL msb_losscnt: got %0d expected 13", mif.loss_cnt_out); end
  endtask

  task automatic test_clr();
    int n = 0;
    mif.rx_commadet_in = 1'b1;
    while (mif.sync_state_out !== RS && n < 50) begin step(); n++; end
    mif.rx_commadet_in = 1'b0;
    mif.rx_encerr_in = 4'b0001;
    mif.clr_cnt_in = 1'b1;
    step();
    mif.rx_encerr_in = 4'b0000;
    mif.clr_cnt_in = 1'b0;
    checks++; if (mif.err_cnt_out !== 16'd0) begin errors++; $display("FAIL clr_errcnt: got %0d expected 0", mif.err_cnt_out); end
    checks++; if (mif.loss_cnt_out !== 16'd0) begin errors++; $display("FAIL clr_losscnt: got %0d expected 0", mif.loss_cnt_out); end
    checks++; if (mif.sync_state_out !== LS) begin errors++; $display("FAIL clr_loss: state=%b expected=%b", mif.sync_state_out, LS); end
  endtask

  task automatic test_reset_mid_pulse();
    int bad = 0;
    acquire(1'b1);
    mif.rx_encerr_in = 4'b0010; repeat (4) step();
    mif.rx_encerr_in = 4'b0000;
    step();
    checks++; if (mif.rx_reset_datapath_out !== 1'b1 || mif.loss_cnt_out !== 16'd1 || mif.err_cnt_out !== 16'd4) begin
      errors++; $display("FAIL rmp_pre: rx=%b loss=%0d err=%0d expected 1/1/4", mif.rx_reset_datapath_out, mif.loss_cnt_out, mif.err_cnt_out); end
    reset = 1'b1;
    step();
    test_reset();
    reset = 1'b0;
    repeat (6) begin
      step();
      if (mif.rx_reset_datapath_out !== 1'b0 || mif.sync_state_out !== LS) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmp_nopulse: %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_saturation();
    int n = 0;
    m2.rx_commadet_in = 1'b1;
    m2.rx_encerr_in = 4'b1000;
    while (m2.err_cnt_out !== 4'hF && n < 400) begin step(); n++; end
    checks++; if (m2.err_cnt_out !== 4'hF) begin errors++; $display("FAIL sat_reach: got %0h expected f", m2.err_cnt_out); end
    repeat (60) step();
    checks++; if (m2.err_cnt_out !== 4'hF) begin errors++; $display("FAIL sat_err: got %0h expected f", m2.err_cnt_out); end
    checks++; if (m2.loss_cnt_out !== 4'hF) begin errors++; $display("FAIL sat_loss: got %0h expected f", m2.loss_cnt_out); end
  endtask

  initial begin
    mif.rx_commadet_in = 1'b0; mif.rx_disperr_in = 4'b0000; mif.rx_encerr_in = 4'b0000;
    mif.handshake_complete_in = 1'b0; mif.clr_cnt_in = 1'b0;
    m2.rx_commadet_in = 1'b0; m2.rx_disperr_in = 4'b0000; m2.rx_encerr_in = 4'b0000;
    m2.handshake_complete_in = 1'b0; m2.clr_cnt_in = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    test_reset();
    test_startup();
    test_err_threshold();
    test_err_window();
    test_comma_during_pulse();
    test_timeout();
    test_disperr_msb();
    test_clr();
    test_reset_mid_pulse();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
